alu_result_stage: RTL

Registered output stage that sits directly downstream of alu_32bit. It captures the ALU result (f_o, cout_o) together with the select code that produced it and derives Z/N/C status flags. Results are delivered to the consumer over a valid/ready handshake. A 2-entry skid buffer keeps ready_o a pure register output, so the consumer's back-pressure never forms a combinational path into the ALU.

---
 rtl/alu_result_stage.sv | 85 ++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered ALU result stage with Z/N/C flags and a 2-entry skid buffer on a valid/ready output.
// Ports: clk_i/rst_ni (async active-low); upstream valid_i, ready_o, f_i, cout_i, sel_i;
// downstream valid_o, ready_i, result_o, flag_z_o, flag_n_o, flag_c_o, op_o.
// Optional: define ALU_RESULT_PARITY_EN to add parity_o (XOR reduction of the captured result).
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] f_i,
  input  logic             cout_i,
  input  logic [3:0]       sel_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_z_o,
  output logic             flag_n_o,
  output logic             flag_c_o,
`ifdef ALU_RESULT_PARITY_EN
  output logic             parity_o,
`endif
  output logic [3:0]       op_o
);
`ifdef ALU_RESULT_PARITY_EN
  localparam int EW = WIDTH + 8;
`else
  localparam int EW = WIDTH + 7;
`endif
  // State bits double as {skid_valid, main_valid}.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  state_t state, next;
  logic [EW-1:0] main_q, skid_q, in_entry;
  logic accept, deliver, load_main, load_skid, move;
  logic carry;
  assign carry = (sel_i[3:2] == 2'b00) & cout_i;
`ifdef ALU_RESULT_PARITY_EN
  assign in_entry = {^f_i, sel_i, carry, f_i[WIDTH-1], ~|f_i, f_i};
  assign parity_o = main_q[EW-1];
`else
  assign in_entry = {sel_i, carry, f_i[WIDTH-1], ~|f_i, f_i};
`endif
  assign {op_o, flag_c_o, flag_n_o, flag_z_o, result_o} = main_q[WIDTH+6:0];
  assign valid_o = state[0];
  assign accept  = valid_i & ready_o;
  assign deliver = valid_o & ready_i;
  always_comb begin
    next      = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move      = 1'b0;
    case (state)
      EMPTY: begin
        next      = accept ? ONE : EMPTY;
        load_main = accept;
      end
      ONE: begin
        next      = (accept & ~deliver) ? FULL : (~accept & deliver) ? EMPTY : ONE;
        load_main = accept & deliver;
        load_skid = accept & ~deliver;
      end
      FULL: begin
        next = deliver ? ONE : FULL;
        move = deliver;
      end
      default: next = EMPTY;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= EMPTY;
      ready_o <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= next;
      // Registered copy of !skid_valid so back-pressure never reaches the ALU combinationally.
      ready_o <= (next != FULL);
      if (load_main) main_q <= in_entry;
      else if (move) main_q <= skid_q;
      if (load_skid) skid_q <= in_entry;
    end
  end
endmodule
